// File: rtl/apb_req_scheduler_pkg.sv
// Shared types and constants for the APB request scheduler.
// Supplies default data width and slave count when definitions.sv has not
// already defined them.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef SLAVES
`define SLAVES 4
`endif

package apb_req_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DERR
    } sched_state_t;

    // Slave-index field in the address, plus the width of the field above it
    // that must be zero for the address to decode.
    localparam int DEC_LSB       = 12;
    localparam int DEC_BITS      = 2;
    localparam int DEC_ZERO_BITS = 4;

    // Starting last_owner at the highest index means requester 0 wins first.
    function automatic int last_owner_reset(input int nreq);
        return nreq - 1;
    endfunction

endpackage

// File: rtl/apb_req_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first eligible requester after
// last_owner, in ascending index order with wrap-around.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [IDX_W-1:0] last_owner,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [NREQ-1:0]  eligible;
    logic [IDX_W-1:0] cand;

    // Scan from the requester after last_owner and take the first one not masked.
    always_comb begin
        eligible = req & ~mask;
        gnt      = '0;
        gnt_idx  = '0;
        any      = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last_owner) + k) % NREQ);
            if (!any && eligible[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/apb_req_scheduler.sv
// Round-robin scheduler sharing one APB master port among NREQ requesters.
// Optional feature: define APB_TIMEOUT_EN to abort transfers whose ACCESS
// phase waits TIMEOUT_CYCLES cycles on PREADY.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef SLAVES
`define SLAVES 4
`endif

module apb_req_scheduler #(
    parameter int NREQ           = 3,
    parameter int WIDTH          = `WIDTH,
    parameter int SLAVES         = `SLAVES,
    parameter int DEC_LSB        = apb_req_scheduler_pkg::DEC_LSB,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_write,
    input  logic [NREQ*32-1:0]      req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic                    rsp_err,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic [WIDTH-1:0]        PADDR,
    output logic [WIDTH-1:0]        PWDATA,
    output logic                    PWRITE,
    output logic                    PENABLE,
    output logic [SLAVES-1:0]       PSEL,
    input  logic [WIDTH-1:0]        PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    import apb_req_scheduler_pkg::*;

    localparam int IDX_W = $clog2(NREQ);

    // The wait counter is 8 bits wide, so the limit has to fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    sched_state_t      state, nxt_state;
    logic [IDX_W-1:0]  owner_idx, nxt_owner_idx;
    logic [IDX_W-1:0]  last_owner, nxt_last_owner;
    logic [NREQ-1:0]   nxt_grant, nxt_done;
    logic              nxt_rsp_err;
    logic [WIDTH-1:0]  nxt_rsp_rdata, nxt_paddr, nxt_pwdata;
    logic              nxt_pwrite, nxt_penable;
    logic [SLAVES-1:0] nxt_psel;

    logic [NREQ-1:0]   arb_mask, arb_gnt;
    logic [IDX_W-1:0]  arb_last, arb_idx;
    logic              arb_any;
    logic              capture;

    logic [31:0]         sel_addr;
    logic [DEC_BITS-1:0] dec_idx;
    logic                dec_err;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tcount, nxt_tcount;
`endif

    // In the completion cycle the current owner is masked and the search starts after it.
    always_comb begin
        arb_mask = '0;
        arb_last = last_owner;
        if (state == ACCESS) begin
            arb_mask = grant;
            arb_last = owner_idx;
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req        (req),
        .mask       (arb_mask),
        .last_owner (arb_last),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    // Decode the slave targeted by whichever requester the arbiter is offering.
    always_comb begin
        sel_addr = req_addr[32*arb_idx +: 32];
        dec_idx  = sel_addr[DEC_LSB +: DEC_BITS];
        dec_err  = (32'(dec_idx) >= SLAVES) ||
                   (sel_addr[DEC_LSB+DEC_BITS +: DEC_ZERO_BITS] != '0);
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        nxt_state      = state;
        nxt_owner_idx  = owner_idx;
        nxt_last_owner = last_owner;
        nxt_grant      = grant;
        nxt_done       = '0;
        nxt_rsp_err    = 1'b0;
        nxt_rsp_rdata  = '0;
        nxt_paddr      = PADDR;
        nxt_pwdata     = PWDATA;
        nxt_pwrite     = PWRITE;
        nxt_penable    = 1'b0;
        nxt_psel       = '0;
        capture        = 1'b0;
`ifdef APB_TIMEOUT_EN
        nxt_tcount     = tcount;
`endif
        unique case (state)
            IDLE: begin
                capture = arb_any;
            end
            SETUP: begin
                nxt_psel    = PSEL;
                nxt_penable = 1'b1;
                nxt_state   = ACCESS;
`ifdef APB_TIMEOUT_EN
                nxt_tcount  = '0;
`endif
            end
            ACCESS: begin
                nxt_psel    = PSEL;
                nxt_penable = 1'b1;
                if (PREADY) begin
                    nxt_done       = grant;
                    nxt_rsp_err    = PSLVERR;
                    nxt_rsp_rdata  = PWRITE ? '0 : PRDATA;
                    nxt_last_owner = owner_idx;
                    nxt_grant      = '0;
                    nxt_psel       = '0;
                    nxt_penable    = 1'b0;
                    nxt_state      = IDLE;
                    capture        = arb_any;
                end
`ifdef APB_TIMEOUT_EN
                else if (tcount == TMO_LIMIT) begin
                    nxt_done       = grant;
                    nxt_rsp_err    = 1'b1;
                    nxt_last_owner = owner_idx;
                    nxt_grant      = '0;
                    nxt_psel       = '0;
                    nxt_penable    = 1'b0;
                    nxt_state      = IDLE;
                end else begin
                    nxt_tcount = tcount + 8'd1;
                end
`endif
            end
            DERR: begin
                nxt_done       = grant;
                nxt_rsp_err    = 1'b1;
                nxt_last_owner = owner_idx;
                nxt_grant      = '0;
                nxt_state      = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        if (capture) begin
            nxt_grant     = arb_gnt;
            nxt_owner_idx = arb_idx;
            if (dec_err) begin
                nxt_state = DERR;
            end else begin
                nxt_state   = SETUP;
                nxt_psel    = SLAVES'(1) << dec_idx;
                nxt_penable = 1'b0;
                nxt_paddr   = WIDTH'(sel_addr);
                nxt_pwdata  = req_wdata[WIDTH*arb_idx +: WIDTH];
                nxt_pwrite  = req_write[arb_idx];
            end
        end
    end

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            owner_idx  <= '0;
            last_owner <= IDX_W'(last_owner_reset(NREQ));
            grant      <= '0;
            done       <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
            PENABLE    <= 1'b0;
            PSEL       <= '0;
`ifdef APB_TIMEOUT_EN
            tcount     <= '0;
`endif
        end else begin
            state      <= nxt_state;
            owner_idx  <= nxt_owner_idx;
            last_owner <= nxt_last_owner;
            grant      <= nxt_grant;
            done       <= nxt_done;
            rsp_err    <= nxt_rsp_err;
            rsp_rdata  <= nxt_rsp_rdata;
            PADDR      <= nxt_paddr;
            PWDATA     <= nxt_pwdata;
            PWRITE     <= nxt_pwrite;
            PENABLE    <= nxt_penable;
            PSEL       <= nxt_psel;
`ifdef APB_TIMEOUT_EN
            tcount     <= nxt_tcount;
`endif
        end
    end

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Directed self-checking bench for apb_req_scheduler.
// Inputs change and outputs are sampled on the falling edge of HCLK.
module tb_apb_req_scheduler;

    localparam int NREQ   = 3;
    localparam int WIDTH  = 32;
    localparam int SLAVES = 4;
    localparam int TMO    = 4;

    logic                  HCLK    = 1'b0;
    logic                  HRESETn = 1'b1;
    logic [NREQ-1:0]       req       = '0;
    logic [NREQ-1:0]       req_write = '0;
    logic [NREQ*32-1:0]    req_addr  = '0;
    logic [NREQ*WIDTH-1:0] req_wdata = '0;
    logic [NREQ-1:0]       grant, done;
    logic                  rsp_err;
    logic [WIDTH-1:0]      rsp_rdata, PADDR, PWDATA;
    logic                  PWRITE, PENABLE;
    logic [SLAVES-1:0]     PSEL;
    logic [WIDTH-1:0]      PRDATA  = '0;
    logic                  PREADY  = 1'b1;
    logic                  PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;

    // Back-to-back table, cycles 1..7 after the three requests are sampled.
    logic [63:0] b2b_done  [1:7] = '{64'h0, 64'h0, 64'h1, 64'h0, 64'h2, 64'h0, 64'h4};
    logic [63:0] b2b_grant [1:7] = '{64'h1, 64'h1, 64'h2, 64'h2, 64'h4, 64'h4, 64'h0};
    logic [63:0] b2b_psel  [1:7] = '{64'h1, 64'h1, 64'h2, 64'h2, 64'h4, 64'h4, 64'h0};
    logic [63:0] b2b_pen   [1:7] = '{64'h0, 64'h1, 64'h0, 64'h1, 64'h0, 64'h1, 64'h0};
    logic [63:0] b2b_wdata [1:7] = '{64'h11111111, 64'h0, 64'h22222222, 64'h0,
                                     64'h33333333, 64'h0, 64'h0};

    apb_req_scheduler #(
        .NREQ(NREQ), .WIDTH(WIDTH), .SLAVES(SLAVES), .DEC_LSB(12), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic applyStimulus(input logic [1:0] idx, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_write[idx]         = wr;
        req_addr[32*idx +: 32] = addr;
        req_wdata[32*idx +: 32] = wdata;
        req[idx]               = 1'b1;
    endtask

    task automatic resetDut();
        HRESETn = 1'b0;
        req     = '0;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        repeat (2) nextCycle();
        HRESETn = 1'b1;
        nextCycle();
    endtask

    initial begin
        #1 HRESETn = 1'b0;
        @(negedge HCLK);
        $display("[TB] reset values");
        checkOutput("rst_grant",   64'(grant),     64'h0);
        checkOutput("rst_done",    64'(done),      64'h0);
        checkOutput("rst_err",     64'(rsp_err),   64'h0);
        checkOutput("rst_rdata",   64'(rsp_rdata), 64'h0);
        checkOutput("rst_paddr",   64'(PADDR),     64'h0);
        checkOutput("rst_pwdata",  64'(PWDATA),    64'h0);
        checkOutput("rst_pwrite",  64'(PWRITE),    64'h0);
        checkOutput("rst_penable", 64'(PENABLE),   64'h0);
        checkOutput("rst_psel",    64'(PSEL),      64'h0);
        HRESETn = 1'b1;
        nextCycle();

        $display("[TB] single read, requester 1");
        applyStimulus(2'd1, 1'b0, 32'h0000_1004, 32'h0);
        PRDATA = 32'hDEAD_BEEF;
        PREADY = 1'b1;
        nextCycle();
        checkOutput("rd_c1_psel",   64'(PSEL),    64'h2);
        checkOutput("rd_c1_pen",    64'(PENABLE), 64'h0);
        checkOutput("rd_c1_grant",  64'(grant),   64'h2);
        checkOutput("rd_c1_paddr",  64'(PADDR),   64'h1004);
        checkOutput("rd_c1_pwrite", 64'(PWRITE),  64'h0);
        nextCycle();
        checkOutput("rd_c2_psel",   64'(PSEL),    64'h2);
        checkOutput("rd_c2_pen",    64'(PENABLE), 64'h1);
        checkOutput("rd_c2_done",   64'(done),    64'h0);
        nextCycle();
        checkOutput("rd_c3_done",   64'(done),      64'h2);
        checkOutput("rd_c3_rdata",  64'(rsp_rdata), 64'hDEAD_BEEF);
        checkOutput("rd_c3_err",    64'(rsp_err),   64'h0);
        checkOutput("rd_c3_psel",   64'(PSEL),      64'h0);
        checkOutput("rd_c3_pen",    64'(PENABLE),   64'h0);
        req = '0;
        nextCycle();
        checkOutput("rd_c4_done",   64'(done),    64'h0);

        $display("[TB] three simultaneous writes");
        resetDut();
        applyStimulus(2'd0, 1'b1, 32'h0000_0010, 32'h1111_1111);
        applyStimulus(2'd1, 1'b1, 32'h0000_1020, 32'h2222_2222);
        applyStimulus(2'd2, 1'b1, 32'h0000_2030, 32'h3333_3333);
        for (int c = 1; c <= 7; c++) begin
            nextCycle();
            checkOutput($sformatf("b2b_c%0d_done", c),  64'(done),    b2b_done[c]);
            checkOutput($sformatf("b2b_c%0d_grant", c), 64'(grant),   b2b_grant[c]);
            checkOutput($sformatf("b2b_c%0d_psel", c),  64'(PSEL),    b2b_psel[c]);
            checkOutput($sformatf("b2b_c%0d_pen", c),   64'(PENABLE), b2b_pen[c]);
            if (b2b_wdata[c] != 64'h0) begin
                checkOutput($sformatf("b2b_c%0d_pwdata", c), 64'(PWDATA), b2b_wdata[c]);
                checkOutput($sformatf("b2b_c%0d_pwrite", c), 64'(PWRITE), 64'h1);
            end
            req = req & ~b2b_done[c][NREQ-1:0];
        end

        $display("[TB] write with three wait states and slave error");
        resetDut();
        applyStimulus(2'd0, 1'b1, 32'h0000_3010, 32'hCAFE_F00D);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            nextCycle();
            if (c <= 5) begin
                checkOutput($sformatf("ws_c%0d_psel", c),   64'(PSEL),    64'h8);
                checkOutput($sformatf("ws_c%0d_pen", c),    64'(PENABLE), (c >= 2) ? 64'h1 : 64'h0);
                checkOutput($sformatf("ws_c%0d_paddr", c),  64'(PADDR),   64'h3010);
                checkOutput($sformatf("ws_c%0d_pwdata", c), 64'(PWDATA),  64'hCAFE_F00D);
                checkOutput($sformatf("ws_c%0d_done", c),   64'(done),    64'h0);
            end else begin
                checkOutput("ws_c6_done",  64'(done),      64'h1);
                checkOutput("ws_c6_err",   64'(rsp_err),   64'h1);
                checkOutput("ws_c6_rdata", 64'(rsp_rdata), 64'h0);
                checkOutput("ws_c6_psel",  64'(PSEL),      64'h0);
            end
            if (c == 5) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end
        end
        req     = '0;
        PSLVERR = 1'b0;
        nextCycle();

        $display("[TB] decode error");
        applyStimulus(2'd0, 1'b0, 32'h0001_0000, 32'h0);
        nextCycle();
        checkOutput("de_c1_psel",  64'(PSEL),  64'h0);
        checkOutput("de_c1_grant", 64'(grant), 64'h1);
        checkOutput("de_c1_done",  64'(done),  64'h0);
        nextCycle();
        checkOutput("de_c2_done",  64'(done),    64'h1);
        checkOutput("de_c2_err",   64'(rsp_err), 64'h1);
        checkOutput("de_c2_psel",  64'(PSEL),    64'h0);
        req = '0;
        nextCycle();
        checkOutput("de_c3_done",  64'(done),  64'h0);

        $display("[TB] reset during ACCESS");
        applyStimulus(2'd1, 1'b1, 32'h0000_2000, 32'h5555_AAAA);
        PREADY = 1'b0;
        nextCycle();
        checkOutput("ar_c1_grant", 64'(grant), 64'h2);
        nextCycle();
        checkOutput("ar_c2_pen",   64'(PENABLE), 64'h1);
        #2 HRESETn = 1'b0;
        #1;
        checkOutput("ar_grant",  64'(grant),   64'h0);
        checkOutput("ar_psel",   64'(PSEL),    64'h0);
        checkOutput("ar_pen",    64'(PENABLE), 64'h0);
        checkOutput("ar_paddr",  64'(PADDR),   64'h0);
        checkOutput("ar_pwdata", 64'(PWDATA),  64'h0);
        checkOutput("ar_pwrite", 64'(PWRITE),  64'h0);
        checkOutput("ar_done",   64'(done),    64'h0);
        req    = '0;
        PREADY = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            checkOutput($sformatf("ar_idle%0d_done", c), 64'(done), 64'h0);
        end
        applyStimulus(2'd0, 1'b0, 32'h0000_0000, 32'h0);
        applyStimulus(2'd1, 1'b0, 32'h0000_1000, 32'h0);
        PRDATA = 32'h0BAD_F00D;
        for (int c = 1; c <= 5; c++) begin
            nextCycle();
            if (c == 1) checkOutput("ar_pri_grant", 64'(grant), 64'h1);
            if (c == 3) begin
                checkOutput("ar_pri_done0",  64'(done),  64'h1);
                checkOutput("ar_pri_grant1", 64'(grant), 64'h2);
                req[0] = 1'b0;
            end
            if (c == 5) begin
                checkOutput("ar_pri_done1",  64'(done),      64'h2);
                checkOutput("ar_pri_rdata1", 64'(rsp_rdata), 64'h0BAD_F00D);
                req[1] = 1'b0;
            end
        end
        nextCycle();

`ifdef APB_TIMEOUT_EN
        $display("[TB] timeout abort");
        applyStimulus(2'd0, 1'b0, 32'h0000_0000, 32'h0);
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        for (int c = 1; c <= 7; c++) begin
            nextCycle();
            if (c == 6) checkOutput("to_c6_pen", 64'(PENABLE), 64'h1);
            if (c == 7) begin
                checkOutput("to_c7_done",  64'(done),      64'h1);
                checkOutput("to_c7_err",   64'(rsp_err),   64'h1);
                checkOutput("to_c7_rdata", 64'(rsp_rdata), 64'h0);
                checkOutput("to_c7_psel",  64'(PSEL),      64'h0);
                checkOutput("to_c7_pen",   64'(PENABLE),   64'h0);
            end
        end
        req = '0;
        nextCycle();

        $display("[TB] PREADY exactly at the limit");
        applyStimulus(2'd0, 1'b0, 32'h0000_0000, 32'h0);
        PREADY = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            nextCycle();
            if (c == 6) PREADY = 1'b1;
            if (c == 7) begin
                checkOutput("tl_c7_done",  64'(done),      64'h1);
                checkOutput("tl_c7_err",   64'(rsp_err),   64'h0);
                checkOutput("tl_c7_rdata", 64'(rsp_rdata), 64'h1234_5678);
            end
        end
        req = '0;
        nextCycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
